// File: rtl/mux_seq_pkg.sv
// Shared types and default timing for the break-before-make mux switch sequencer.
package mux_seq_pkg;

    typedef enum logic [2:0] {
        OFF,
        BREAK,
        ADDR,
        SETTLE,
        READY
    } seq_state_t;

    // Default timing in 100 MHz cycles.
    localparam int unsigned T_BREAK_DEF  = 4;   // 40 ns with every path disabled
    localparam int unsigned T_ADDR_DEF   = 19;  // ADG1206 address-to-data 185 ns + margin
    localparam int unsigned T_SETTLE_DEF = 12;  // 115 ns enable latency + margin

    localparam int unsigned N_CH_DEF  = 32;
    localparam int unsigned CH_W_DEF  = 6;
    localparam int unsigned CNT_W_DEF = 8;

    // Completed-switch counter holds at all-ones instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/mux_switch_sequencer_if.sv
// Request/status bundle between the protocol slave and the switch sequencer.
interface mux_switch_sequencer_if
    import mux_seq_pkg::*;
#(
    parameter int unsigned CH_W = CH_W_DEF
);
    logic            req_valid;
    logic [CH_W-1:0] req_ch;
    logic [CH_W-1:0] sel_ch;
    logic            out_en;
    logic            switching_ready;
    logic            busy;
    logic            req_err;
    logic [15:0]     switch_count;

    // Requester side (protocol slave / status logic).
    modport master (
        output req_valid, req_ch,
        input  sel_ch, out_en, switching_ready, busy, req_err, switch_count
    );

    // Sequencer side.
    modport slave (
        input  req_valid, req_ch,
        output sel_ch, out_en, switching_ready, busy, req_err, switch_count
    );

endinterface

// File: rtl/seq_timer.sv
// Down-counter for the timed sequencer states: a load of v raises expire_o for one
// cycle, v cycles after the load cycle.
module seq_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             expire_o
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Load wins over counting; the counter parks at zero once it has run out.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Last counted cycle; the count reaches zero on the following edge, so this is a single pulse.
    assign expire_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mux_switch_sequencer.sv
// Break-before-make sequencer: every channel change disables all senders and muxes,
// applies the new address, waits for the address to settle, enables, then waits for
// the enable to settle before reporting switching_ready.
module mux_switch_sequencer
    import mux_seq_pkg::*;
#(
    parameter int unsigned N_CH     = N_CH_DEF,
    parameter int unsigned CH_W     = CH_W_DEF,
    parameter int unsigned T_BREAK  = T_BREAK_DEF,
    parameter int unsigned T_ADDR   = T_ADDR_DEF,
    parameter int unsigned T_SETTLE = T_SETTLE_DEF,
    parameter int unsigned CNT_W    = CNT_W_DEF
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    mux_switch_sequencer_if.slave  seq_if
);

    seq_state_t      state_q;
    logic [CH_W-1:0] target_q, target_d;
    logic [CH_W-1:0] sel_ch_q;
    logic            out_en_q;
    logic            ready_q;
    logic            busy_q;
    logic            req_err_q;
    logic [15:0]     count_q;

    logic             req_ok, req_bad, req_new;
    logic             in_seq, start, restart;
    logic             tmr_load, tmr_expire;
    logic [CNT_W-1:0] tmr_val;

    // Request decode, target update and timer reload for whichever timed state is entered next.
    always_comb begin
        req_ok  = seq_if.req_valid && (32'(seq_if.req_ch) < N_CH);
        req_bad = seq_if.req_valid && !(32'(seq_if.req_ch) < N_CH);
        // A request for the channel already targeted never disturbs a sequence or READY.
        req_new = req_ok && (seq_if.req_ch != target_q);
        in_seq  = (state_q == BREAK) || (state_q == ADDR) || (state_q == SETTLE);
        // From OFF there is no valid channel yet, so any in-range request starts a switch.
        start   = ((state_q == OFF) && req_ok) || ((state_q == READY) && req_new);
        // A new target after the address was applied must go back through BREAK.
        restart = req_new && ((state_q == ADDR) || (state_q == SETTLE));

        target_d = target_q;
        if (start || (in_seq && req_new)) begin
            target_d = seq_if.req_ch;
        end

        tmr_load = 1'b0;
        tmr_val  = CNT_W'(T_BREAK);
        if (start || restart) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(T_BREAK);
        end else if (tmr_expire && (state_q == BREAK)) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(T_ADDR);
        end else if (tmr_expire && (state_q == ADDR)) begin
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(T_SETTLE);
        end
    end

    seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk_i      (clock_i),
        .rst_i      (reset_i),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .expire_o   (tmr_expire)
    );

    // Sequencer FSM with registered outputs; sel_ch only moves on ADDR entry, while out_en is low.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q   <= OFF;
            target_q  <= '0;
            sel_ch_q  <= '0;
            out_en_q  <= 1'b0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            req_err_q <= 1'b0;
            count_q   <= '0;
        end else begin
            req_err_q <= req_bad;
            target_q  <= target_d;
            case (state_q)
                OFF, READY: begin
                    if (start) begin
                        state_q  <= BREAK;
                        out_en_q <= 1'b0;
                        ready_q  <= 1'b0;
                        busy_q   <= 1'b1;
                    end
                end
                BREAK: begin
                    if (tmr_expire) begin
                        state_q  <= ADDR;
                        // A request in the last BREAK cycle still wins.
                        sel_ch_q <= target_d;
                    end
                end
                ADDR: begin
                    if (restart) begin
                        state_q <= BREAK;
                    end else if (tmr_expire) begin
                        state_q  <= SETTLE;
                        out_en_q <= 1'b1;
                    end
                end
                SETTLE: begin
                    // Restart has priority over expiry so an aborted switch never reports ready.
                    if (restart) begin
                        state_q  <= BREAK;
                        out_en_q <= 1'b0;
                    end else if (tmr_expire) begin
                        state_q <= READY;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b0;
                        count_q <= sat_inc16(count_q);
                    end
                end
                default: begin
                    state_q  <= OFF;
                    out_en_q <= 1'b0;
                    ready_q  <= 1'b0;
                    busy_q   <= 1'b0;
                end
            endcase
        end
    end

    assign seq_if.sel_ch          = sel_ch_q;
    assign seq_if.out_en          = out_en_q;
    assign seq_if.switching_ready = ready_q;
    assign seq_if.busy            = busy_q;
    assign seq_if.req_err         = req_err_q;
    assign seq_if.switch_count    = count_q;

endmodule

// File: tb/tb_mux_switch_sequencer.sv
// Self-checking bench for mux_switch_sequencer: scenario tasks plus a scoreboard that
// predicts each switching_ready rise and req_err pulse (channel, count, cycle).
module tb_mux_switch_sequencer;

    localparam int unsigned T_ADDR = 19;
    localparam int unsigned LAT    = 36;  // 1 + 4 + 19 + 12

    typedef struct {
        logic [5:0]  ch;
        logic [15:0] cnt;
        int          due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc     = 0;
    int   n_checks = 0;
    int   n_pass   = 0;

    exp_t exp_q[$];
    int   err_q[$];

    mux_switch_sequencer_if #(.CH_W(6)) bus ();

    mux_switch_sequencer dut (
        .clock_i (clk),
        .reset_i (reset),
        .seq_if  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Cycle index: the cycle after edge k has cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard and safety monitors, sampled mid-cycle.
    logic       ready_prev = 1'b0;
    logic       oe_prev    = 1'b0;
    logic       rst_prev   = 1'b1;
    logic [5:0] sel_prev   = '0;
    int         stable     = 0;
    always @(negedge clk) begin
        exp_t e;
        int   d;
        int   stable_now;
        if (bus.switching_ready && !ready_prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL sb_ready: unexpected ready at cycle %0d sel=%0d", cyc, bus.sel_ch);
            end else begin
                e = exp_q.pop_front();
                if (bus.sel_ch !== e.ch || bus.switch_count !== e.cnt || cyc != e.due)
                    $display("FAIL sb_ready: got ch=%0d cnt=%0d cyc=%0d want ch=%0d cnt=%0d cyc=%0d",
                             bus.sel_ch, bus.switch_count, cyc, e.ch, e.cnt, e.due);
                else n_pass++;
            end
        end
        if (bus.req_err === 1'b1) begin
            n_checks++;
            if (err_q.size() == 0) begin
                $display("FAIL sb_err: unexpected req_err at cycle %0d", cyc);
            end else begin
                d = err_q.pop_front();
                if (cyc != d) $display("FAIL sb_err: got cycle %0d want %0d", cyc, d);
                else n_pass++;
            end
        end
        stable_now = (bus.sel_ch != sel_prev) ? 1 : stable + 1;
        if (!reset && !rst_prev) begin
            if (bus.sel_ch != sel_prev) begin
                n_checks++;
                if (bus.out_en || oe_prev)
                    $display("FAIL sel_while_en: sel %0d->%0d with out_en %0b->%0b", sel_prev,
                             bus.sel_ch, oe_prev, bus.out_en);
                else n_pass++;
            end
            if (bus.out_en && !oe_prev) begin
                n_checks++;
                if (stable_now <= T_ADDR)
                    $display("FAIL addr_setup: got %0d stable cycles want >%0d", stable_now, T_ADDR);
                else n_pass++;
            end
        end
        stable     <= stable_now;
        ready_prev <= bus.switching_ready;
        oe_prev    <= bus.out_en;
        sel_prev   <= bus.sel_ch;
        rst_prev   <= reset;
    end

    task automatic go_to(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drive a one-cycle request in the current cycle; returns one cycle later.
    task automatic send(input logic [5:0] ch);
        bus.req_ch    = ch;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_ch = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++; if (bus.sel_ch !== 6'd0) $display("FAIL rst_sel: got %0d want 0", bus.sel_ch); else n_pass++;
        n_checks++; if (bus.out_en !== 1'b0) $display("FAIL rst_out_en: got %0b want 0", bus.out_en); else n_pass++;
        n_checks++; if (bus.switching_ready !== 1'b0) $display("FAIL rst_ready: got %0b want 0", bus.switching_ready); else n_pass++;
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", bus.busy); else n_pass++;
        n_checks++; if (bus.req_err !== 1'b0) $display("FAIL rst_req_err: got %0b want 0", bus.req_err); else n_pass++;
        n_checks++; if (bus.switch_count !== 16'd0) $display("FAIL rst_count: got %0d want 0", bus.switch_count); else n_pass++;
    endtask

    task automatic test_first_switch();
        int c0 = cyc;
        exp_q.push_back('{ch: 6'd5, cnt: 16'd1, due: c0 + LAT});
        send(6'd5);
        n_checks++; if (bus.busy !== 1'b1) $display("FAIL first_busy: got %0b want 1", bus.busy); else n_pass++;
        go_to(c0 + 4);
        n_checks++; if (bus.sel_ch !== 6'd0) $display("FAIL first_sel_break: got %0d want 0", bus.sel_ch); else n_pass++;
        go_to(c0 + 5);
        n_checks++; if (bus.sel_ch !== 6'd5) $display("FAIL first_sel_addr: got %0d want 5", bus.sel_ch); else n_pass++;
        go_to(c0 + 23);
        n_checks++; if (bus.out_en !== 1'b0) $display("FAIL first_oe_early: got %0b want 0", bus.out_en); else n_pass++;
        go_to(c0 + 24);
        n_checks++; if (bus.out_en !== 1'b1) $display("FAIL first_oe: got %0b want 1", bus.out_en); else n_pass++;
        go_to(c0 + 35);
        n_checks++; if (bus.switching_ready !== 1'b0) $display("FAIL first_ready_early: got %0b want 0", bus.switching_ready); else n_pass++;
        go_to(c0 + 36);
        n_checks++; if (bus.switching_ready !== 1'b1 || bus.busy !== 1'b0)
            $display("FAIL first_ready: got ready=%0b busy=%0b want 1/0", bus.switching_ready, bus.busy); else n_pass++;
    endtask

    task automatic test_same_and_range();
        int c0 = cyc;
        send(6'd5);
        n_checks++; if (bus.busy !== 1'b0 || bus.switching_ready !== 1'b1 || bus.switch_count !== 16'd1)
            $display("FAIL same_ch: got busy=%0b ready=%0b cnt=%0d want 0/1/1", bus.busy,
                     bus.switching_ready, bus.switch_count); else n_pass++;
        go_to(c0 + 4);
        c0 = cyc;
        err_q.push_back(c0 + 1);
        send(6'd40);
        n_checks++; if (bus.req_err !== 1'b1 || bus.sel_ch !== 6'd5 || bus.switching_ready !== 1'b1)
            $display("FAIL range_40: got err=%0b sel=%0d ready=%0b want 1/5/1", bus.req_err,
                     bus.sel_ch, bus.switching_ready); else n_pass++;
        go_to(c0 + 2);
        n_checks++; if (bus.req_err !== 1'b0) $display("FAIL range_pulse: got %0b want 0", bus.req_err); else n_pass++;
        c0 = cyc;
        err_q.push_back(c0 + 1);
        send(6'd32);
        n_checks++; if (bus.busy !== 1'b0) $display("FAIL range_32: got busy=%0b want 0", bus.busy); else n_pass++;
        go_to(c0 + 3);
        // Highest legal channel starts a switch; a bad request mid-sequence must not disturb it.
        c0 = cyc;
        exp_q.push_back('{ch: 6'd31, cnt: 16'd2, due: c0 + LAT});
        send(6'd31);
        n_checks++; if (bus.busy !== 1'b1 || bus.req_err !== 1'b0)
            $display("FAIL range_31: got busy=%0b err=%0b want 1/0", bus.busy, bus.req_err); else n_pass++;
        go_to(c0 + 10);
        err_q.push_back(c0 + 11);
        send(6'd63);
        go_to(c0 + LAT + 1);
    endtask

    task automatic test_break_overwrite();
        int c0 = cyc;
        int seen7 = 0;
        send(6'd7);
        go_to(c0 + 3);
        exp_q.push_back('{ch: 6'd9, cnt: 16'd3, due: c0 + LAT});
        send(6'd9);
        go_to(c0 + 4);
        n_checks++; if (bus.sel_ch !== 6'd31) $display("FAIL ovr_sel_old: got %0d want 31", bus.sel_ch); else n_pass++;
        go_to(c0 + 5);
        n_checks++; if (bus.sel_ch !== 6'd9) $display("FAIL ovr_sel_new: got %0d want 9", bus.sel_ch); else n_pass++;
        while (cyc < c0 + LAT) begin
            if (bus.sel_ch == 6'd7) seen7++;
            @(posedge clk);
            #1;
        end
        n_checks++; if (seen7 != 0) $display("FAIL ovr_no7: got %0d cycles of ch7 want 0", seen7); else n_pass++;
        go_to(c0 + LAT + 1);
    endtask

    task automatic test_settle_abort();
        int c0 = cyc;
        int c1;
        send(6'd7);
        go_to(c0 + 24);
        n_checks++; if (bus.out_en !== 1'b1 || bus.sel_ch !== 6'd7)
            $display("FAIL abort_pre: got oe=%0b sel=%0d want 1/7", bus.out_en, bus.sel_ch); else n_pass++;
        c1 = cyc;
        exp_q.push_back('{ch: 6'd9, cnt: 16'd4, due: c1 + LAT});
        send(6'd9);
        n_checks++; if (bus.out_en !== 1'b0 || bus.busy !== 1'b1)
            $display("FAIL abort_drop: got oe=%0b busy=%0b want 0/1", bus.out_en, bus.busy); else n_pass++;
        go_to(c0 + LAT);
        n_checks++; if (bus.switching_ready !== 1'b0) $display("FAIL abort_no_ready: got %0b want 0", bus.switching_ready); else n_pass++;
        go_to(c1 + 5);
        n_checks++; if (bus.sel_ch !== 6'd9) $display("FAIL abort_sel: got %0d want 9", bus.sel_ch); else n_pass++;
        go_to(c1 + LAT + 1);
    endtask

    task automatic test_expiry_race();
        int c0 = cyc;
        int c1;
        send(6'd7);
        go_to(c0 + 35);
        c1 = cyc;
        exp_q.push_back('{ch: 6'd3, cnt: 16'd5, due: c1 + LAT});
        send(6'd3);
        n_checks++; if (bus.switching_ready !== 1'b0 || bus.busy !== 1'b1 || bus.out_en !== 1'b0 || bus.switch_count !== 16'd4)
            $display("FAIL race: got ready=%0b busy=%0b oe=%0b cnt=%0d want 0/1/0/4", bus.switching_ready,
                     bus.busy, bus.out_en, bus.switch_count); else n_pass++;
        go_to(c1 + LAT + 1);
    endtask

    task automatic test_reset_mid();
        int c0 = cyc;
        send(6'd11);
        go_to(c0 + 10);
        n_checks++; if (bus.sel_ch !== 6'd11 || bus.out_en !== 1'b0)
            $display("FAIL mid_addr: got sel=%0d oe=%0b want 11/0", bus.sel_ch, bus.out_en); else n_pass++;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++; if (bus.sel_ch !== 6'd0 || bus.out_en !== 1'b0 || bus.switching_ready !== 1'b0 ||
                        bus.busy !== 1'b0 || bus.req_err !== 1'b0 || bus.switch_count !== 16'd0)
            $display("FAIL mid_reset: got sel=%0d oe=%0b rdy=%0b busy=%0b err=%0b cnt=%0d want all 0",
                     bus.sel_ch, bus.out_en, bus.switching_ready, bus.busy, bus.req_err,
                     bus.switch_count); else n_pass++;
        c0 = cyc;
        exp_q.push_back('{ch: 6'd12, cnt: 16'd1, due: c0 + LAT});
        send(6'd12);
        go_to(c0 + LAT + 1);
        n_checks++; if (bus.switch_count !== 16'd1 || bus.sel_ch !== 6'd12)
            $display("FAIL mid_after: got cnt=%0d sel=%0d want 1/12", bus.switch_count, bus.sel_ch); else n_pass++;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_first_switch();
        test_same_and_range();
        test_break_overwrite();
        test_settle_abort();
        test_expiry_race();
        test_reset_mid();
        go_to(cyc + 2);
        n_checks++; if (exp_q.size() != 0) $display("FAIL sb_ready_left: got %0d pending want 0", exp_q.size()); else n_pass++;
        n_checks++; if (err_q.size() != 0) $display("FAIL sb_err_left: got %0d pending want 0", err_q.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
